// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus between the decode stage (master) and the
// latency-aware hazard scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int REG_W = 4,
    parameter int LAT_W = 3
);
    localparam int NUM_REGS = 2 ** REG_W;

    logic                id_valid;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;
    logic                id_rs_used;
    logic                id_rt_used;
    logic                id_branch;
    logic                id_store;
    logic                id_wr_en;
    logic [REG_W-1:0]    id_rd;
    logic [LAT_W-1:0]    id_lat;
    logic                freeze;
    logic                stall;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_branch,
               id_store, id_wr_en, id_rd, id_lat, freeze,
        input  stall, busy_vec
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_branch,
               id_store, id_wr_en, id_rd, id_lat, freeze,
        output stall, busy_vec
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Latency-aware hazard scoreboard for the in-order pipeline.
// One countdown per architectural register holds the cycles remaining until
// the pending producer's value reaches the ID-stage bypass; decode operands
// are compared against it to drive a combinational stall.
// Optional: define HAZARD_STATS_EN to add a saturating stall_cycles counter.
module hazard_scoreboard #(
    parameter int REG_W = 4,
    parameter int LAT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave sb
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);
    localparam int NUM_REGS = 2 ** REG_W;
    localparam int CNT_W    = LAT_W + 1;

    typedef logic [CNT_W-1:0] cnt_t;

    cnt_t cnt_q [NUM_REGS];
    cnt_t cnt_d [NUM_REGS];

    logic rs_hazard;
    logic rt_hazard;
    logic stall;
    logic issue;
    cnt_t new_lat;

    // Bypass reachability threshold depends on where the consumer needs it:
    // branches resolve in ID, store data is needed one stage later than ALU operands.
    function automatic logic src_hazard(input cnt_t c, input logic is_branch,
                                        input logic is_store_data);
        if (is_branch)
            src_hazard = (c != '0);
        else if (is_store_data)
            src_hazard = (c > cnt_t'(2));
        else
            src_hazard = (c > cnt_t'(1));
    endfunction

    function automatic cnt_t count_down(input cnt_t c);
        count_down = (c != '0) ? (c - cnt_t'(1)) : '0;
    endfunction

    // Hazard detection and issue qualification from registered counters.
    always_comb begin
        rs_hazard = sb.id_rs_used & src_hazard(cnt_q[sb.id_rs], sb.id_branch, 1'b0);
        rt_hazard = sb.id_rt_used & src_hazard(cnt_q[sb.id_rt], sb.id_branch, sb.id_store);
        stall     = sb.id_valid & (rs_hazard | rt_hazard);
        issue     = sb.id_valid & ~stall & ~sb.freeze;
        sb.stall  = stall;
    end

    // Counter next-state: hold on freeze, load on issued write, else count down.
    always_comb begin
        new_lat = cnt_t'(sb.id_lat) + cnt_t'(1);
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (sb.freeze) begin
                cnt_d[r] = cnt_q[r];
            end else if (issue && sb.id_wr_en && (sb.id_rd == REG_W'(r)) && (r != 0)) begin
                // WAW: the older, longer-latency producer still gates readers.
                cnt_d[r] = (new_lat > count_down(cnt_q[r])) ? new_lat : count_down(cnt_q[r]);
            end else begin
                cnt_d[r] = count_down(cnt_q[r]);
            end
        end
        cnt_d[0] = '0;
    end

    // Scoreboard counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    // Busy flags are a direct view of the registered counters.
    always_comb begin
        sb.busy_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            sb.busy_vec[r] = (cnt_q[r] != '0);
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    // Saturating count of stall cycles that actually cost a pipeline slot.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !sb.freeze && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    // Stall statistics register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, latency-aware hazard unit for the in-order pipeline. It replaces fixed single-cycle load-use and branch-operand comparisons with a per-register countdown scoreboard, so multi-cycle producers (slow loads, multiplies) stall dependent instructions in decode for exactly the required number of cycles. It sits beside the ID stage: it reads decode operands, records each issued writer, and drives the pipeline stall.

## Interface
Parameters:
- `REG_W`, 4, architectural register index width; `NUM_REGS = 2**REG_W` registers tracked.
- `LAT_W`, 3, width of the `id_lat` field; producer latency range is 0..2**LAT_W-1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `id_valid`  in  1  a valid instruction is in ID.
- `id_rs`, `id_rt`  in  REG_W  source register indices.
- `id_rs_used`, `id_rt_used`  in  1  the corresponding source is actually read.
- `id_branch`  in  1  the ID instruction resolves a branch in ID.
- `id_store`  in  1  the ID instruction is a store; `rt` is store data.
- `id_wr_en`, `id_rd`  in  1, REG_W  the ID instruction writes `id_rd`.
- `id_lat`  in  LAT_W  extra cycles after EX before the result can be forwarded. ALU op = 0, single-cycle load = 1.
- `freeze`  in  1  global pipeline hold (memory wait). No issue occurs and counters hold.
- `stall`  out  1  combinational: hold IF/ID and inject a bubble into EX.
- `busy_vec`  out  NUM_REGS  bit r = scoreboard counter r is non-zero (registered).

## Operation
- State: one counter `cnt[r]` per register, LAT_W+1 bits wide. `cnt[0]` is hardwired 0, and register 0 is never a hazard.
- `cnt[r]` is the number of cycles until the producer's value is available at the ID-stage bypass.
- Per-source hazard, evaluated for a used source `s` with `c = cnt[s]`:
  - Branch consumer: hazard if `c > 0`.
  - Store-data source (`id_store` and source is `rt`): hazard if `c > 2`.
  - Otherwise: hazard if `c > 1`.
  - For a branch store, branch rules take precedence.
- `stall = id_valid & (hazard on rs | hazard on rt)`.
- Issue happens when `id_valid & ~stall & ~freeze`.
- Counter update per register, on each edge:
  - If `freeze`: hold.
  - Else if issuing with `id_wr_en`, `id_rd == r`, `r != 0`: load `max(id_lat + 1, cnt[r] - 1)`. WAW hazards keep the longer pending latency.
  - Else if `cnt[r] != 0`: decrement.
  - Else: hold at 0.
- No saturation or wrap: `id_lat + 1 <= 2**LAT_W` always fits in LAT_W+1 bits.

## Timing
- Reset (`rst_n` low at an edge): all `cnt` = 0, `busy_vec` = 0. `stall` is then 0 for any input.
- Reset mid-stall clears all pending state on that edge. Reset overrides `freeze` and issue.
- `stall` is combinational from registered `cnt` and the ID inputs, with zero-cycle latency. `busy_vec` is the registered state.
- Load-use (`id_lat`=1), issued at cycle 0:
  - `cnt`=2 at cycle 1: ALU consumer stalls.
  - `cnt`=1 at cycle 2: consumer issues; a branch consumer still stalls.
  - `cnt`=0 at cycle 3: branch issues.
- ALU producer (`id_lat`=0) feeding a branch: exactly one stall cycle. An ALU consumer gets no stall.
- `freeze` high: `stall` is still reported, counters and `busy_vec` hold, and no issue is recorded.
- The ID instruction's own `id_rd` never self-hazards in the same cycle; only `cnt` state is compared.

## Configuration
- Macro `HAZARD_STATS_EN`.
- Defined:
  - Adds output `stall_cycles` (32 bits).
  - Reset value 0.
  - Increments each edge where `stall & ~freeze`.
  - Saturates at 0xFFFF_FFFF.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** drive `rst_n`=0 for 2 cycles with `cnt` preloaded by prior issues -> `busy_vec`=0, `stall`=0 afterwards; `stall_cycles`=0 if enabled.
- **Load-use:** issue load r3, `id_lat`=1; next `add` reads rs=r3 -> `stall`=1 for exactly 1 cycle, issues at cycle 2.
- **Branch dependencies:**
  - ALU r5 `id_lat`=0, then `beq` on r5 -> 1 stall cycle.
  - Load r5 `id_lat`=1, then `beq` on r5 -> 2 stall cycles.
  - Register r0 as destination -> 0 stalls.
- **Store data:** load r4 `id_lat`=1, then store with rt=r4 -> no stall. Store with rs=r4 -> 1 stall.
- **Long latency and WAW:**
  - Producer r7 `id_lat`=7 -> ALU consumer stalls 7 cycles.
  - Issue r7 `id_lat`=1 while `cnt[7]`=5 -> counter becomes 4, not 2.
- **Freeze:** `freeze`=1 for 3 cycles during a load-use stall -> `busy_vec` unchanged and the stall is extended by 3 cycles; `stall_cycles` counts only unfrozen stall cycles.
